// File: rtl/rdc_pkg.sv
// Shared definitions for the RDC interrupt controller slice: default sizes,
// index-width helper and the controller state encoding.
package rdc_pkg;

  localparam int RDC_N_CORES       = 2;
  localparam int RDC_CORE_EVENTS   = 4;
  localparam int RDC_WEIGHTS_WIDTH = 8;
  localparam int RDC_TS_WIDTH      = 32;
  localparam int N_COUNTERS        = RDC_N_CORES * RDC_CORE_EVENTS;

  // Width needed to index n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    IDLE,
    PENDING
  } rdc_irq_state_t;

endpackage

// File: rtl/rdc_watermark.sv
// Per-event high-watermark: counts the current pulse length and keeps the
// longest one seen, saturating at the all-ones value.
module rdc_watermark #(
  parameter int WEIGHTS_WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     enable_i,
  input  logic                     event_i,
  input  logic                     clear_wm_i,
  output logic [WEIGHTS_WIDTH-1:0] watermark_o
);

  localparam logic [WEIGHTS_WIDTH-1:0] WMAX = '1;

  logic [WEIGHTS_WIDTH-1:0] run_reg;
  logic [WEIGHTS_WIDTH-1:0] run_inc;
  logic [WEIGHTS_WIDTH-1:0] wm_reg;
  logic                     hit;

  assign hit     = enable_i & event_i;
  assign run_inc = (run_reg == WMAX) ? WMAX : run_reg + 1'b1;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      run_reg <= '0;
      wm_reg  <= '0;
    end else begin
      run_reg <= hit ? run_inc : '0;
      // The incremented count covers the current sample, so a pulse of n
      // cycles lands as n right after its last high sample.
      if (clear_wm_i)
        wm_reg <= '0;
      else if (hit && (run_inc > wm_reg))
        wm_reg <= run_inc;
    end
  end

  assign watermark_o = wm_reg;

endmodule

// File: rtl/rdc_irq_ctrl.sv
// Converts the registered RDC violation vector into a level interrupt with
// sticky masked status, first-offender capture, overflow and pulse watermarks.
module rdc_irq_ctrl
  import rdc_pkg::*;
#(
  parameter int N_CORES       = RDC_N_CORES,
  parameter int CORE_EVENTS   = RDC_CORE_EVENTS,
  parameter int WEIGHTS_WIDTH = RDC_WEIGHTS_WIDTH,
  parameter int TS_WIDTH      = RDC_TS_WIDTH,
  localparam int NC           = N_CORES * CORE_EVENTS,
  localparam int CORE_W       = idx_width(N_CORES),
  localparam int EVT_W        = idx_width(CORE_EVENTS)
) (
  input  logic                                 clk_i,
  input  logic                                 rstn_i,
  input  logic                                 enable_i,
  input  logic [N_CORES-1:0][CORE_EVENTS-1:0]  events_i,
  input  logic [N_CORES-1:0][CORE_EVENTS-1:0]  interruption_vector_rdc_i,
  input  logic [N_CORES-1:0][CORE_EVENTS-1:0]  mask_i,
  input  logic                                 clear_i,
  input  logic                                 clear_wm_i,
  output logic                                 irq_o,
  output logic [N_CORES-1:0][CORE_EVENTS-1:0]  status_o,
  output logic [CORE_W-1:0]                    first_core_o,
  output logic [EVT_W-1:0]                     first_event_o,
  output logic [TS_WIDTH-1:0]                  first_ts_o,
  output logic                                 overflow_o,
  output logic [NC-1:0][WEIGHTS_WIDTH-1:0]     watermark_o
);

  rdc_irq_state_t     state_reg, state_next;
  logic [TS_WIDTH-1:0] ts_reg;
  logic [NC-1:0]       status_reg, status_next;
  logic [CORE_W-1:0]   first_core_reg, first_core_next;
  logic [EVT_W-1:0]    first_event_reg, first_event_next;
  logic [TS_WIDTH-1:0] first_ts_reg, first_ts_next;
  logic                overflow_reg, overflow_next;
  logic [NC-1:0]       m_flat;
  logic [NC-1:0]       ev_flat;
  int                  enc_idx;

  assign m_flat  = interruption_vector_rdc_i & mask_i;
  assign ev_flat = events_i;

  // Lowest set flat index wins, so scan from the top down.
  always_comb begin
    enc_idx = 0;
    for (int k = NC - 1; k >= 0; k--) begin
      if (m_flat[k]) enc_idx = k;
    end
  end

  always_comb begin
    state_next       = state_reg;
    status_next      = status_reg;
    first_core_next  = first_core_reg;
    first_event_next = first_event_reg;
    first_ts_next    = first_ts_reg;
    overflow_next    = overflow_reg;
    if (clear_i) begin
      state_next       = IDLE;
      status_next      = '0;
      first_core_next  = '0;
      first_event_next = '0;
      first_ts_next    = '0;
      overflow_next    = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (enable_i && (|m_flat)) begin
            state_next       = PENDING;
            status_next      = status_reg | m_flat;
            first_core_next  = CORE_W'(enc_idx / CORE_EVENTS);
            first_event_next = EVT_W'(enc_idx % CORE_EVENTS);
            first_ts_next    = ts_reg;
          end
        end
        PENDING: begin
          if (enable_i) begin
            status_next = status_reg | m_flat;
            if (|(m_flat & ~status_reg)) overflow_next = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg       <= IDLE;
      ts_reg          <= '0;
      status_reg      <= '0;
      first_core_reg  <= '0;
      first_event_reg <= '0;
      first_ts_reg    <= '0;
      overflow_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      if (enable_i) ts_reg <= ts_reg + 1'b1;
      status_reg      <= status_next;
      first_core_reg  <= first_core_next;
      first_event_reg <= first_event_next;
      first_ts_reg    <= first_ts_next;
      overflow_reg    <= overflow_next;
    end
  end

  assign irq_o         = (state_reg == PENDING);
  assign status_o      = status_reg;
  assign first_core_o  = first_core_reg;
  assign first_event_o = first_event_reg;
  assign first_ts_o    = first_ts_reg;
  assign overflow_o    = overflow_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NC; gi++) begin : g_wm
      rdc_watermark #(
        .WEIGHTS_WIDTH(WEIGHTS_WIDTH)
      ) u_wm (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .enable_i   (enable_i),
        .event_i    (ev_flat[gi]),
        .clear_wm_i (clear_wm_i),
        .watermark_o(watermark_o[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_rdc_irq_ctrl.sv
// Directed bench for rdc_irq_ctrl: capture, priority, mask, clear, overflow,
// asynchronous reset and watermark saturation/clear/restart.
module tb_rdc_irq_ctrl;

  logic            clk_i = 1'b0;
  logic            rstn_i;
  logic            enable_i;
  logic [1:0][3:0] events_i;
  logic [1:0][3:0] vec_i;
  logic [1:0][3:0] mask_i;
  logic            clear_i;
  logic            clear_wm_i;
  logic            irq_o;
  logic [1:0][3:0] status_o;
  logic [0:0]      first_core_o;
  logic [1:0]      first_event_o;
  logic [31:0]     first_ts_o;
  logic            overflow_o;
  logic [7:0][7:0] watermark_o;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] ts_model = 0;
  logic [31:0] exp_ts;

  always #5 clk_i = ~clk_i;

  rdc_irq_ctrl dut (
    .clk_i                    (clk_i),
    .rstn_i                   (rstn_i),
    .enable_i                 (enable_i),
    .events_i                 (events_i),
    .interruption_vector_rdc_i(vec_i),
    .mask_i                   (mask_i),
    .clear_i                  (clear_i),
    .clear_wm_i               (clear_wm_i),
    .irq_o                    (irq_o),
    .status_o                 (status_o),
    .first_core_o             (first_core_o),
    .first_event_o            (first_event_o),
    .first_ts_o               (first_ts_o),
    .overflow_o               (overflow_o),
    .watermark_o              (watermark_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock edge; the timestamp model follows the enable seen at that edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      if (enable_i) ts_model = ts_model + 1;
      #1;
    end
  endtask

  initial begin
    rstn_i = 1'b0; enable_i = 1'b0; events_i = '0; vec_i = '0;
    mask_i = '0; clear_i = 1'b0; clear_wm_i = 1'b0;
    #12;
    chk("rst_irq", irq_o, 0);
    chk("rst_status", status_o, 0);
    chk("rst_wm0", watermark_o[0], 0);
    rstn_i = 1'b1; enable_i = 1'b1; mask_i = 8'hFF;

    // single offender core1/event2 at ts=10
    step(10);
    chk("pre_irq", irq_o, 0);
    vec_i = 8'h40; exp_ts = ts_model;
    step();
    vec_i = '0;
    chk("cap_ts_is_10", exp_ts, 10);
    chk("cap_irq", irq_o, 1);
    chk("cap_core", first_core_o, 1);
    chk("cap_event", first_event_o, 2);
    chk("cap_ts", first_ts_o, exp_ts);
    chk("cap_status", status_o, 8'h40);
    chk("cap_ovf", overflow_o, 0);
    clear_i = 1'b1; step(); clear_i = 1'b0;
    chk("clr_irq", irq_o, 0);
    chk("clr_ts", first_ts_o, 0);

    // two offenders at once, then a late one while pending
    vec_i = 8'h18; step();
    chk("pri_core", first_core_o, 0);
    chk("pri_event", first_event_o, 3);
    chk("pri_status", status_o, 8'h18);
    chk("pri_ovf", overflow_o, 0);
    vec_i = 8'h02; step(); vec_i = '0;
    chk("ovf_set", overflow_o, 1);
    chk("ovf_status", status_o, 8'h1A);
    chk("ovf_event", first_event_o, 3);

    // asynchronous reset while pending
    #2 rstn_i = 1'b0; #1;
    chk("arst_irq", irq_o, 0);
    chk("arst_status", status_o, 0);
    chk("arst_ovf", overflow_o, 0);
    rstn_i = 1'b1; ts_model = 0;
    step();
    chk("arst_idle", irq_o, 0);

    // masked violation, then unmask with the vector still high
    mask_i = 8'hBF; vec_i = 8'h40; step(2);
    chk("mask_irq", irq_o, 0);
    chk("mask_status", status_o, 0);
    mask_i = 8'hFF; step();
    chk("unmask_irq", irq_o, 1);
    chk("unmask_stat", status_o, 8'h40);

    // clear wins over a concurrent violation, which re-triggers next cycle
    vec_i = 8'h01; clear_i = 1'b1; step(); clear_i = 1'b0;
    chk("clrpri_irq", irq_o, 0);
    chk("clrpri_stat", status_o, 0);
    exp_ts = ts_model; step();
    chk("retrig_irq", irq_o, 1);
    chk("retrig_ts", first_ts_o, exp_ts);
    chk("retrig_stat", status_o, 8'h01);
    vec_i = '0; clear_i = 1'b1; step(); clear_i = 1'b0;

    // disabled: no capture
    enable_i = 1'b0; vec_i = 8'h80; step(2);
    chk("dis_irq", irq_o, 0);
    enable_i = 1'b1; vec_i = '0; step();

    // watermarks on event [0][0]
    events_i = 8'h01; step(5); events_i = '0;
    chk("wm_pulse5", watermark_o[0], 5);
    step(2); events_i = 8'h01; step(3); events_i = '0; step();
    chk("wm_keep5", watermark_o[0], 5);
    chk("wm_other", watermark_o[7], 0);
    events_i = 8'h01; step(300); events_i = '0; step();
    chk("wm_sat", watermark_o[0], 255);
    events_i = 8'h01; clear_wm_i = 1'b1; step(); clear_wm_i = 1'b0; events_i = '0;
    chk("wm_clr", watermark_o[0], 0);
    step();
    events_i = 8'h01; step(3);
    enable_i = 1'b0; step();
    enable_i = 1'b1; step(3); events_i = '0; step();
    chk("wm_restart", watermark_o[0], 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rdc_irq_ctrl.md
Name: rdc_irq_ctrl

Overview:
- Consumer of the Request Duration Counter (RDC) output.
- Turns the registered per-event violation vector into a software-visible interrupt:
  - sticky status with mask,
  - first-offender capture (core, event, timestamp),
  - overflow flag.
- Also keeps a per-event high-watermark of pulse duration, so software can tune the RDC weights.
- Sits between the RDC and the SoC interrupt controller / register interface.

Parameters:
N_CORES, 2, number of monitored cores
CORE_EVENTS, 4, events per core
WEIGHTS_WIDTH, 8, width of duration watermarks (matches RDC weight width)
TS_WIDTH, 32, width of free-running timestamp

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
enable_i  in  1  active-high enable; gates timestamp, watermarks and new captures
events_i  in  [CORE_EVENTS] x N_CORES  raw monitored events (same array shape as RDC input)
interruption_vector_rdc_i  in  [CORE_EVENTS] x N_CORES  registered RDC violation vector
mask_i  in  [CORE_EVENTS] x N_CORES  1 = violation may set status/raise irq
clear_i  in  1  single-cycle pulse: clear status, first-offender, overflow, irq
clear_wm_i  in  1  single-cycle pulse: clear all watermarks
irq_o  out  1  level interrupt, high while state is PENDING
status_o  out  [CORE_EVENTS] x N_CORES  sticky masked violations
first_core_o  out  max(1,$clog2(N_CORES))  core index of first offender
first_event_o  out  max(1,$clog2(CORE_EVENTS))  event index of first offender
first_ts_o  out  TS_WIDTH  timestamp at first capture
overflow_o  out  1  sticky: new offender bit seen while PENDING
watermark_o  out  WEIGHTS_WIDTH x (N_CORES*CORE_EVENTS)  max observed pulse length, flat index k=c*CORE_EVENTS+e

Behaviour:
- Reset: all outputs, the timestamp counter and all run counters are 0; state is IDLE.
- Timestamp:
  - ts increments by 1 each cycle while enable_i; holds when enable_i=0.
  - Wraps modulo 2^TS_WIDTH.
- Masked vector: m = interruption_vector_rdc_i & mask_i.
- FSM IDLE:
  - If enable_i and any m bit is set, next cycle:
    - status_o |= m;
    - capture the lowest flat index k set in m (first_core=k/CORE_EVENTS, first_event=k%CORE_EVENTS);
    - first_ts_o = ts value of the sampling cycle;
    - irq_o=1; go to PENDING.
  - Latency: violation sampled at cycle t gives irq_o high at t+1.
- FSM PENDING:
  - While enable_i, status_o |= m.
  - If m has a bit not already in status_o, overflow_o <= 1.
  - First-offender fields hold.
- clear_i:
  - Takes effect in any state; next cycle state=IDLE and status_o, first_* , overflow_o, irq_o are all 0.
  - clear_i has priority over capture in the same cycle; that cycle's m is dropped.
  - A still-asserted violation re-triggers on the following cycle.
- enable_i=0: no new captures and no status updates; existing status/irq/first-offender are held until clear_i.
- Watermark, per k (one instance each):
  - Run counter r: if enable_i & event high, r <= sat(r+1); otherwise r <= 0.
  - wm <= max(wm, sat(r+1)) on the same condition.
  - Saturates at 2^WEIGHTS_WIDTH-1, never wraps.
  - A pulse of n cycles gives wm=n, visible the cycle after the last high sample.
  - clear_wm_i zeroes wm (clear wins over update in the same cycle); r is unaffected.
- Events and the vector are assumed synchronous to clk_i; no internal synchronisers.

Decomposition:
- Shared package rdc_pkg:
  - localparam N_COUNTERS = N_CORES*CORE_EVENTS;
  - index-width helper function (min width 1);
  - typedef enum {IDLE, PENDING} rdc_irq_state_t.
- Sub-module rdc_watermark: one run counter plus one saturating max register, generated N_COUNTERS times.
- Priority encoder and FSM live in rdc_irq_ctrl.

Test Plan:
- Reset mid-PENDING (irq_o=1, status≠0): assert rstn_i=0 asynchronously -> all outputs 0 immediately, no clock edge needed; after release, IDLE.
- All masks 1, vector bit core1/event2 at cycle 10 (ts=10) -> irq_o=1 at cycle 11, first_core=1, first_event=2, first_ts=10, status bit [1][2]=1, overflow_o=0.
- Bits [0][3] and [1][0] set in the same cycle -> first_core=0, first_event=3; both status bits set; overflow_o=0. Later [0][1] rises while PENDING -> overflow_o=1 next cycle.
- mask_i[1][2]=0, vector [1][2] asserted -> irq_o stays 0, status_o stays 0; unmask with the vector still high -> irq_o=1 one cycle later.
- clear_i pulsed while vector [0][0] is still high -> next cycle irq_o=0 and status_o=0; following cycle irq_o=1 again with a fresh first_ts.
- Watermarks, events [0][0], WEIGHTS_WIDTH=8:
  - pulses of 5 then 3 cycles -> watermark_o[0]=5;
  - a 300-cycle pulse -> watermark_o[0]=255;
  - clear_wm_i -> 0;
  - enable_i=0 mid-pulse -> run counter restarts from 0.
